// File: rtl/ysyx_22041412_csr_ctrl_if.sv
// Request/response and CSR-side bundle for the CSR access controller.
// Latency: none (wiring only).
// Backpressure: req_valid/req_ready upstream, csr_valid/csr_ready toward the CSR file.
interface ysyx_22041412_csr_ctrl_if;
    // upstream request
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_pc;
    logic [2:0]  req_func3;
    logic [3:0]  req_csr;
    logic [63:0] req_wdata;
    // upstream response
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    // CSR file side
    logic        csr_en;
    logic        csr_valid;
    logic [63:0] csr_pc;
    logic [3:0]  csr_addr;
    logic [2:0]  csr_func3;
    logic [63:0] csr_wdata;
    logic [63:0] csr_rdata;
    logic        csr_ready;

    // environment view: issues requests and plays the CSR responder
    modport master (
        output req_valid, req_pc, req_func3, req_csr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err, redirect_valid, redirect_pc,
        input  csr_en, csr_valid, csr_pc, csr_addr, csr_func3, csr_wdata,
        output csr_rdata, csr_ready
    );

    // controller view
    modport slave (
        input  req_valid, req_pc, req_func3, req_csr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err, redirect_valid, redirect_pc,
        output csr_en, csr_valid, csr_pc, csr_addr, csr_func3, csr_wdata,
        input  csr_rdata, csr_ready
    );
endinterface

// File: rtl/ysyx_22041412_csr_ctrl.sv
// Sequences CSR ops, ecall (cause write + mtvec fetch) and mret (mepc fetch) against an external CSR file.
// Latency: illegal 1 cycle to resp; CSR op/mret 2+wait; ecall 4+waits; each access gives up after RESP_TIMEOUT stalled cycles.
// Backpressure: req_ready only in IDLE (one request in flight); csr_ready stalls the access, csr_ready with csr_en=0 is ignored.
module ysyx_22041412_csr_ctrl #(
    parameter int RESP_TIMEOUT = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    ysyx_22041412_csr_ctrl_if.slave        bus
);
    typedef enum logic [2:0] {IDLE, ACCESS, VEC, EPC, RESP} state_t;

    localparam logic [3:0] CSR_MTVEC = 4'h3;
    localparam logic [3:0] CSR_MEPC  = 4'h4;
    localparam logic [3:0] CSR_ECALL = 4'hb;
    localparam logic [3:0] CSR_MRET  = 4'hc;
    localparam logic [3:0] TIMEOUT   = 4'(RESP_TIMEOUT);

    // every output comes straight from this register
    typedef struct packed {
        logic        req_ready;
        logic        resp_valid;
        logic [63:0] resp_rdata;
        logic        resp_err;
        logic        redirect_valid;
        logic [63:0] redirect_pc;
        logic        csr_en;
        logic [63:0] csr_pc;
        logic [3:0]  csr_addr;
        logic [2:0]  csr_func3;
        logic [63:0] csr_wdata;
    } ctrl_out_t;

    state_t     state, state_nxt;
    ctrl_out_t  out_q, out_d;
    logic [3:0] cnt, cnt_nxt, cnt_inc;
    logic       is_ecall, is_ecall_nxt;
    logic       vec_gap, vec_gap_nxt;   // VEC's first cycle keeps csr_en low so the ecall update settles
    logic       op_legal;

    assign bus.req_ready      = out_q.req_ready;
    assign bus.resp_valid     = out_q.resp_valid;
    assign bus.resp_rdata     = out_q.resp_rdata;
    assign bus.resp_err       = out_q.resp_err;
    assign bus.redirect_valid = out_q.redirect_valid;
    assign bus.redirect_pc    = out_q.redirect_pc;
    assign bus.csr_en         = out_q.csr_en;
    assign bus.csr_valid      = out_q.csr_en;
    assign bus.csr_pc         = out_q.csr_pc;
    assign bus.csr_addr       = out_q.csr_addr;
    assign bus.csr_func3      = out_q.csr_func3;
    assign bus.csr_wdata      = out_q.csr_wdata;

    // State, wait counter, sequencing flags and the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            is_ecall <= 1'b0;
            vec_gap  <= 1'b0;
            out_q    <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            is_ecall <= is_ecall_nxt;
            vec_gap  <= vec_gap_nxt;
            out_q    <= out_d;
        end
    end

    // Next state and next output values; completions first, then the stall/timeout override.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        is_ecall_nxt = is_ecall;
        vec_gap_nxt  = vec_gap;
        out_d        = out_q;
        cnt_inc      = cnt + 4'd1;
        op_legal     = (bus.req_func3 inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111})
                       && (bus.req_csr >= 4'd1) && (bus.req_csr <= 4'd6);

        case (state)
            IDLE: begin
                out_d.req_ready      = 1'b1;
                out_d.resp_valid     = 1'b0;
                out_d.resp_err       = 1'b0;
                out_d.redirect_valid = 1'b0;
                out_d.csr_en         = 1'b0;
                if (bus.req_valid && out_q.req_ready) begin
                    out_d.req_ready = 1'b0;
                    out_d.csr_pc    = bus.req_pc;
                    out_d.csr_wdata = bus.req_wdata;
                    out_d.csr_func3 = bus.req_func3;
                    out_d.csr_addr  = bus.req_csr;
                    cnt_nxt         = 4'd0;
                    if (op_legal) begin
                        state_nxt    = ACCESS;
                        out_d.csr_en = 1'b1;
                        is_ecall_nxt = 1'b0;
                    end else if (bus.req_func3 == 3'b000 && bus.req_csr == CSR_ECALL) begin
                        state_nxt    = ACCESS;
                        out_d.csr_en = 1'b1;
                        is_ecall_nxt = 1'b1;
                    end else if (bus.req_func3 == 3'b000 && bus.req_csr == CSR_MRET) begin
                        state_nxt      = EPC;
                        out_d.csr_en   = 1'b1;
                        out_d.csr_addr = CSR_MEPC;
                    end else begin
                        state_nxt        = RESP;
                        out_d.resp_valid = 1'b1;
                        out_d.resp_err   = 1'b1;
                        out_d.resp_rdata = 64'h0;
                    end
                end
            end
            ACCESS: begin
                if (bus.csr_ready) begin
                    out_d.csr_en = 1'b0;
                    if (is_ecall) begin
                        state_nxt       = VEC;
                        vec_gap_nxt     = 1'b1;
                        out_d.csr_addr  = CSR_MTVEC;
                        out_d.csr_func3 = 3'b000;
                    end else begin
                        state_nxt        = RESP;
                        out_d.resp_valid = 1'b1;
                        out_d.resp_rdata = bus.csr_rdata;
                        out_d.resp_err   = 1'b0;
                    end
                end
            end
            VEC, EPC: begin
                if (vec_gap) begin
                    vec_gap_nxt  = 1'b0;
                    out_d.csr_en = 1'b1;
                    cnt_nxt      = 4'd0;
                end else if (bus.csr_ready) begin
                    state_nxt            = RESP;
                    out_d.csr_en         = 1'b0;
                    out_d.resp_valid     = 1'b1;
                    out_d.resp_err       = 1'b0;
                    out_d.redirect_valid = 1'b1;
                    out_d.redirect_pc    = bus.csr_rdata;
                end
            end
            RESP: begin
                state_nxt            = IDLE;
                out_d.req_ready      = 1'b1;
                out_d.resp_valid     = 1'b0;
                out_d.resp_err       = 1'b0;
                out_d.redirect_valid = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (out_q.csr_en && (state inside {ACCESS, VEC, EPC}) && !bus.csr_ready) begin
            if (cnt_inc == TIMEOUT) begin
                state_nxt            = RESP;
                out_d.csr_en         = 1'b0;
                out_d.resp_valid     = 1'b1;
                out_d.resp_err       = 1'b1;
                out_d.resp_rdata     = 64'h0;
                out_d.redirect_valid = 1'b0;
            end else begin
                cnt_nxt = cnt_inc;
            end
        end
    end
endmodule
